// File: rtl/bram_logger.sv
// Capture buffer for the filtered sample stream: one start-framed pass into block RAM,
// then an addressed read port with a two-cycle latency serves the record to the host.
module bram_logger #(
  parameter int WW_DATA = 8,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic [WW_DATA-1:0] i_data,
  input  logic               i_start,
  input  logic               i_rd_req,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [WW_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_busy,
  output logic               o_full,
  output logic [NB_ADDR:0]   o_count
);
  localparam int DEPTH  = 2**NB_ADDR;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t             state;
  logic [NB_ADDR-1:0] wr_ptr;
  logic [WW_DATA-1:0] mem [DEPTH];
  logic [WW_DATA-1:0] rd_q;
  logic [STAGES:0]    vld_pipe;
  logic               wr_en, rd_en, last_wr;

  assign wr_en   = (state == CAPTURE) && i_en;
  assign rd_en   = (state == DONE) && i_rd_req;
  assign last_wr = (wr_ptr == {NB_ADDR{1'b1}});

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      o_count <= '0;
      o_busy  <= 1'b0;
      o_full  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (i_start) begin
          state   <= CAPTURE;
          wr_ptr  <= '0;
          o_count <= '0;
          o_busy  <= 1'b1;
          o_full  <= 1'b0;
        end
        CAPTURE: if (i_en) begin
          wr_ptr  <= wr_ptr + {{(NB_ADDR-1){1'b0}}, 1'b1};
          o_count <= o_count + {{NB_ADDR{1'b0}}, 1'b1};
          // final slot written: stop here, the pointer never starts a second pass
          if (last_wr) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_full <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_full <= 1'b0;
        end
      endcase
    end
  end

  // RAM array and its read register are left unreset so they map onto block RAM
  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wr_ptr] <= i_data;
    if (rd_en) rd_q <= mem[i_rd_addr];
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vld_pipe  <= '0;
      o_rd_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_en};
      if (vld_pipe[STAGES-1]) o_rd_data <= rd_q;
    end
  end

  assign o_rd_valid = vld_pipe[STAGES];
endmodule

// File: doc/bram_logger.md
# bram_logger

Capture buffer that sits downstream of the FIR filter. It records the filtered sample stream into an internal block-RAM on each sample-enable strobe, then makes the stored record available to a host through an addressed read port. The FIR filter produces the stream; this block consumes it and serves it back out. A start/full handshake frames each capture.

## Interface
- `WW_DATA`, 8: sample width. Signed, two's complement. Matches the filter `WW_OUTPUT`.
- `NB_ADDR`, 10: address width. Buffer depth is `DEPTH = 2**NB_ADDR`.

- `i_clock`  in  1: single clock. All logic is rising-edge.
- `i_reset`  in  1: asynchronous, active-low reset.
- `i_en`  in  1: sample strobe. Same strobe that advances the filter.
- `i_data`  in  WW_DATA: filtered sample. Signed.
- `i_start`  in  1: single-cycle request to start a capture.
- `i_rd_req`  in  1: read request. One address per cycle.
- `i_rd_addr`  in  NB_ADDR: read address.
- `o_rd_data`  out  WW_DATA: read data.
- `o_rd_valid`  out  1: one-cycle qualifier for `o_rd_data`.
- `o_busy`  out  1: high while a capture is in progress.
- `o_full`  out  1: high when the buffer holds a complete record.
- `o_count`  out  NB_ADDR+1: number of samples written in the current or last capture.

## Operation
- **FSM states:** IDLE, CAPTURE, DONE.
- **Reset** (`i_reset`=0, asynchronous): state goes to IDLE. `o_busy`=0, `o_full`=0, `o_count`=0, `o_rd_valid`=0, `o_rd_data`=0, write pointer=0. RAM contents are not reset.
- **IDLE:**
  - `i_start`=1 moves to CAPTURE and clears the write pointer and `o_count`.
  - `i_en` is ignored.
  - `i_rd_req` is ignored.
- **CAPTURE:**
  - Each cycle with `i_en`=1 writes `mem[wr_ptr] <= i_data`, then increments `wr_ptr` and `o_count`.
  - The write with `wr_ptr`=DEPTH-1 is the last one. On the next edge the state goes to DONE with `o_count`=DEPTH. The pointer does not wrap into a second pass.
  - `i_start` is ignored.
  - `i_rd_req` is ignored.
- **DONE:**
  - `i_rd_req`=1 is accepted every cycle. Back-to-back reads are allowed and there is no stall.
  - `i_start`=1 returns to CAPTURE and clears the pointer and `o_count`.
  - `i_en` is ignored.
- **Data path:** samples are stored bit-exact. There is no arithmetic, truncation or saturation.
- **Outputs by state:**
  - `o_busy` = (state == CAPTURE).
  - `o_full` = (state == DONE).

## Timing
- **Start:** `i_start` sampled at edge k moves the state after edge k. The earliest write is at edge k+1. If `i_en`=1 in the same cycle as `i_start` from IDLE or DONE, that sample is not captured.
- **Write:** takes effect at the edge where `i_en`=1 is sampled in CAPTURE. `o_count` shows the new value after that edge.
- **End of capture:** if the last write happens at edge m, `o_busy` falls and `o_full` rises after edge m. `o_count`=DEPTH from the same edge.
- **Read latency is 2 cycles:**
  - Request sampled at edge k (state DONE before edge k).
  - RAM is read at edge k.
  - The output register loads at edge k+1.
  - `o_rd_valid`=1 for exactly the cycle after edge k+1.
  - A stream of N requests gives N consecutive valid cycles.
- **Read data hold:** `o_rd_data` holds its last value while `o_rd_valid`=0.
- **Read and start in the same cycle in DONE:** the read is accepted and returns pre-capture data, because the RAM read at edge k precedes any new write. Reads already in flight always complete.
- **Reset mid-operation:** reset during CAPTURE or during an in-flight read forces all outputs to their reset values immediately. Any pending `o_rd_valid` is dropped.

## Test plan
Scenarios use `NB_ADDR`=3 (DEPTH=8) and `WW_DATA`=8 unless stated.

1. **Reset:** assert `i_reset`=0 mid-clock with random inputs -> immediately `o_busy`=0, `o_full`=0, `o_count`=0, `o_rd_valid`=0, `o_rd_data`=0. Check these hold until the first `i_start`.
2. **Contiguous capture:** pulse `i_start`, then 8 cycles of `i_en`=1 with `i_data`=0x80,0x81,…,0x87 -> `o_count` steps 1..8. After the 8th write edge, `o_busy`=0, `o_full`=1, `o_count`=8. Then set `i_en`=1, `i_data`=0x55 for 4 more cycles -> no change to RAM or `o_count`.
3. **Gapped capture:** use `i_en` one cycle in three with `i_data`=-3,-2,…,4 -> capture completes after 8 strobes. A readback of addresses 0..7 returns 0xFD,0xFE,0xFF,0x00,…,0x04.
4. **Readback timing:** in DONE, issue 8 back-to-back `i_rd_req` cycles for addresses 7,6,…,0 -> `o_rd_valid` is high for 8 consecutive cycles starting 2 cycles after the first request, with data 0x87,…,0x80. A request in IDLE or CAPTURE gives no `o_rd_valid`.
5. **Restart collision:** in DONE, assert `i_start`, `i_rd_req` (addr 0) and `i_en`=1 with data 0x11 in one cycle -> the read returns the old 0x80, the 0x11 is not captured, and `o_count`=0. The next strobe with 0x22 writes address 0.
6. **Reset mid-capture:** after 5 writes, pulse `i_reset` -> state is IDLE and `o_count`=0. A new capture starts cleanly from address 0.
